// File: rtl/if_fetch_pkg.sv
// Shared fetch-side definitions: bus widths, IF state encodings, prefetch entry layout.
// The entry carries a fault bit only when IBUS_ERR_EN is defined.
package if_fetch_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWord     = 32'h0000_0000;
    localparam logic               NoStop       = 1'b0;
    localparam logic               BranchEnable = 1'b1;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_RUN   = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;

    typedef struct packed {
`ifdef IBUS_ERR_EN
        logic                   fault;
`endif
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_ent_t;

    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] a);
        return {a[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction bus (req/gnt/rvalid). master = fetch unit, slave = memory side.
// ibus_err_i exists only when IBUS_ERR_EN is defined.
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic                   ibus_req_o;
    logic [InstAddrBus-1:0] ibus_addr_o;
    logic                   ibus_gnt_i;
    logic                   ibus_rvalid_i;
    logic [InstBus-1:0]     ibus_rdata_i;
`ifdef IBUS_ERR_EN
    logic                   ibus_err_i;
`endif

    modport master (
        output ibus_req_o, ibus_addr_o,
`ifdef IBUS_ERR_EN
        input  ibus_err_i,
`endif
        input  ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i
    );

    modport slave (
        input  ibus_req_o, ibus_addr_o,
`ifdef IBUS_ERR_EN
        output ibus_err_i,
`endif
        output ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i
    );

endinterface

// File: rtl/if_fetch_fifo.sv
// Prefetch FIFO of fetch entries with synchronous clear; head is combinational.
// Latency: one cycle push-to-head. No internal backpressure: caller never pushes into a full FIFO unless popping.
module if_fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     pop_dat,
    output logic             empty,
    output logic [CNT_W-1:0] cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Full with simultaneous push and pop is legal: both pointers advance, count holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign empty   = (cnt == '0);

endmodule

// File: rtl/if_fetch.sv
// In-order instruction fetch into a small prefetch FIFO feeding IF/ID; optional IBUS_ERR_EN fault path.
// Latency: first instruction valid two cycles after the first granted request (gnt + 1-cycle rvalid).
// Backpressure: stalled[1] holds the head; requests throttle on FIFO space plus outstanding count.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stalled,
    input  logic [5:0]             flush,
    input  logic                   ex_branch_flag_i,
    input  logic [InstAddrBus-1:0] ex_branch_addr_i,
    if_fetch_if.master             ibus,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o,
`ifdef IBUS_ERR_EN
    output logic                   inst_fault_o,
`endif
    output logic                   inst_valid_o
);

    localparam int CW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1) + 1;

    if_state_e              state_q, state_d;
    logic [InstAddrBus-1:0] fetch_pc_q;
    logic [InstAddrBus-1:0] resp_pc_q;
    logic [InstAddrBus-1:0] stale_addr_q;
    logic                   stale_q;
    logic                   pend_q;
    logic [CW-1:0]          outst_q, outst_d;
    logic [CW-1:0]          discard_q, discard_d;
    logic [CW-1:0]          fifo_cnt;
    logic                   fifo_empty;
    fetch_ent_t             push_ent, head_ent;

    logic redirect, can_issue, req, gnt_fire, rvalid, rsp_drop, push, pop, fault_blk;
    logic unused_bits;

    assign unused_bits = ^{stalled[5:2], stalled[0], flush[5:1], ex_branch_addr_i[1:0]};

`ifdef IBUS_ERR_EN
    logic fault_q;
    assign fault_blk = fault_q;
`else
    assign fault_blk = 1'b0;
`endif

    assign redirect = (ex_branch_flag_i == BranchEnable) | flush[0];
    assign rvalid   = ibus.ibus_rvalid_i;

    assign can_issue = (state_q != IF_IDLE) && !fault_blk
                    && ((fifo_cnt + outst_q) < CW'(FIFO_DEPTH))
                    && (outst_q < CW'(MAX_OUTSTANDING));
    // A request left ungranted must stay on the bus, whatever the issue rule now says.
    assign req      = pend_q | can_issue;
    assign gnt_fire = req & ibus.ibus_gnt_i;

    assign ibus.ibus_req_o  = req;
    assign ibus.ibus_addr_o = stale_q ? stale_addr_q : fetch_pc_q;

    assign rsp_drop = rvalid && (discard_q != '0);
    assign push     = rvalid && (discard_q == '0) && !redirect;
    assign pop      = (stalled[1] == NoStop) && !fifo_empty && !redirect;

    assign outst_d = outst_q + CW'(gnt_fire) - CW'(rvalid);
    // On redirect every request already on the bus (granted or still pending) is stale.
    assign discard_d = redirect ? (outst_q + CW'(req) - CW'(rvalid))
                                : (discard_q - CW'(rsp_drop));

    always_comb begin
        push_ent      = '0;
        push_ent.pc   = resp_pc_q;
        push_ent.inst = ibus.ibus_rdata_i;
`ifdef IBUS_ERR_EN
        push_ent.fault = ibus.ibus_err_i;
`endif
    end

    if_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fetch_ent_t)),
        .CNT_W (CW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (redirect),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .pop_dat  (head_ent),
        .empty    (fifo_empty),
        .cnt      (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IF_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IF_IDLE:  state_d = IF_RUN;
            IF_RUN:   if (redirect && (discard_d != '0)) state_d = IF_DRAIN;
            IF_DRAIN: if (discard_d == '0) state_d = IF_RUN;
            default:  state_d = IF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q   <= word_align(RESET_PC);
            resp_pc_q    <= ZeroWord;
            stale_addr_q <= ZeroWord;
            stale_q      <= 1'b0;
            pend_q       <= 1'b0;
            outst_q      <= '0;
            discard_q    <= '0;
        end else begin
            outst_q   <= outst_d;
            discard_q <= discard_d;
            pend_q    <= req && !ibus.ibus_gnt_i;

            if (redirect) begin
                fetch_pc_q <= word_align(ex_branch_addr_i);
            end else if (gnt_fire && !stale_q) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end

            if (redirect && req && !ibus.ibus_gnt_i) begin
                stale_q      <= 1'b1;
                stale_addr_q <= ibus.ibus_addr_o;
            end else if (gnt_fire) begin
                stale_q <= 1'b0;
            end

            // resp_pc_q tracks the pc of the next word that will be kept, in request order.
            if (redirect) begin
                resp_pc_q <= word_align(ex_branch_addr_i);
            end else if (state_q == IF_IDLE) begin
                resp_pc_q <= fetch_pc_q;
            end else if (push) begin
                resp_pc_q <= resp_pc_q + 32'd4;
            end
        end
    end

`ifdef IBUS_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else if (redirect) begin
            fault_q <= 1'b0;
        end else if (push && ibus.ibus_err_i) begin
            fault_q <= 1'b1;
        end
    end

    assign inst_fault_o = !fifo_empty && head_ent.fault;
`endif

    assign inst_valid_o = !fifo_empty;
    assign pc_o         = fifo_empty ? resp_pc_q : head_ent.pc;
    assign inst_o       = fifo_empty ? ZeroWord  : head_ent.inst;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: bus model with grant budget, scoreboards for grant addresses and delivered pc/inst.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stalled, flush;
    logic        br_flag;
    logic [31:0] br_addr;
    logic [31:0] pc_o, inst_o;
    logic        inst_valid;
`ifdef IBUS_ERR_EN
    logic        inst_fault;
    logic        err_en;
    logic [31:0] err_addr;
`endif

    int          tests = 0;
    int          fails = 0;
    int          budget;
    logic        gnt_en, rsp_hold;
    logic [32:0] exp_q[$];
    logic [31:0] addr_exp[$];
    logic [31:0] rsp_q[$];

    always #5 clk = ~clk;

    if_fetch_if bus ();

    assign bus.ibus_gnt_i = bus.ibus_req_o & gnt_en & (budget != 0);

    if_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .stalled          (stalled),
        .flush            (flush),
        .ex_branch_flag_i (br_flag),
        .ex_branch_addr_i (br_addr),
        .ibus             (bus),
        .pc_o             (pc_o),
        .inst_o           (inst_o),
`ifdef IBUS_ERR_EN
        .inst_fault_o     (inst_fault),
`endif
        .inst_valid_o     (inst_valid)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        logic [31:0] r;
        r = {16'hC0DE, a[15:0]};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: records grants, answers one word per cycle in order, one cycle after gnt.
    initial begin
        logic        fire;
        logic [31:0] a, r;
        bus.ibus_rvalid_i = 1'b0;
        bus.ibus_rdata_i  = '0;
`ifdef IBUS_ERR_EN
        bus.ibus_err_i    = 1'b0;
`endif
        forever begin
            @(negedge clk);
            fire = bus.ibus_req_o & bus.ibus_gnt_i;
            a    = bus.ibus_addr_o;
            @(posedge clk);
            #1;
            if (!rst) begin
                rsp_q.delete();
                bus.ibus_rvalid_i = 1'b0;
                bus.ibus_rdata_i  = '0;
            end else begin
                if (fire) begin
                    budget--;
                    rsp_q.push_back(a);
                    if (addr_exp.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_grant: got addr %h, none expected", a);
                    end else begin
                        check("grant_addr", a, addr_exp.pop_front());
                    end
                end
                if (!rsp_hold && rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    bus.ibus_rvalid_i = 1'b1;
                    bus.ibus_rdata_i  = inst_of(r);
`ifdef IBUS_ERR_EN
                    bus.ibus_err_i    = err_en && (r == err_addr);
`endif
                end else begin
                    bus.ibus_rvalid_i = 1'b0;
                    bus.ibus_rdata_i  = '0;
`ifdef IBUS_ERR_EN
                    bus.ibus_err_i    = 1'b0;
`endif
                end
            end
        end
    end

    // Output monitor: every consumed instruction must match the next expected pc.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (inst_valid && !stalled[1] && !(br_flag | flush[0])) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_inst: got pc %h, none expected", pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_pc", pc_o, e[31:0]);
                        check("out_inst", inst_o, inst_of(e[31:0]));
`ifdef IBUS_ERR_EN
                        check("out_fault", {31'b0, inst_fault}, {31'b0, e[32]});
`endif
                    end
                end else if (!inst_valid) begin
                    check("bubble_inst", inst_o, 32'h0);
                end
            end
        end
    end

    task automatic do_reset(input int b);
        rst = 1'b0;
        #1;
        check("rst_req", {31'b0, bus.ibus_req_o}, 32'h0);
        check("rst_addr", bus.ibus_addr_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        repeat (3) tick();
        stalled  = '0;
        flush    = '0;
        br_flag  = 1'b0;
        gnt_en   = 1'b1;
        rsp_hold = 1'b0;
        exp_q.delete();
        addr_exp.delete();
        budget   = b;
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_req();
        int k = 0;
        while (!bus.ibus_req_o && k < 20) begin
            tick();
            k++;
        end
        check("req_seen", {31'b0, bus.ibus_req_o}, 32'h1);
    endtask

    task automatic wait_drain(input int n);
        int k = 0;
        while ((exp_q.size() != 0 || addr_exp.size() != 0) && k < n) begin
            tick();
            k++;
        end
        check("drain_left", 32'(exp_q.size() + addr_exp.size()), 32'h0);
        exp_q.delete();
        addr_exp.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        stalled  = '0;
        flush    = '0;
        br_flag  = 1'b0;
        br_addr  = '0;
        gnt_en   = 1'b1;
        rsp_hold = 1'b0;
        budget   = 0;
`ifdef IBUS_ERR_EN
        err_en   = 1'b0;
        err_addr = '0;
`endif
        #2;

        // 1: straight-line fetch, first-word latency
        do_reset(8);
        for (int i = 0; i < 8; i++) begin
            addr_exp.push_back(32'(i * 4));
            exp_q.push_back({1'b0, 32'(i * 4)});
        end
        wait_req();
        check("t1_first_addr", bus.ibus_addr_o, 32'h0);
        tick();
        check("t1_valid_early", {31'b0, inst_valid}, 32'h0);
        tick();
        check("t1_valid", {31'b0, inst_valid}, 32'h1);
        check("t1_pc", pc_o, 32'h0);
        wait_drain(60);

        // 2: hold IF/ID for 3 cycles
        do_reset(6);
        for (int i = 0; i < 6; i++) begin
            addr_exp.push_back(32'(i * 4));
            exp_q.push_back({1'b0, 32'(i * 4)});
        end
        wait_req();
        tick();
        tick();
        stalled = 6'b000010;
        check("t2_req_full", {31'b0, bus.ibus_req_o}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_req_stall", {31'b0, bus.ibus_req_o}, 32'h0);
            check("t2_pc_hold", pc_o, 32'h0);
            check("t2_inst_hold", inst_o, inst_of(32'h0));
            check("t2_valid_hold", {31'b0, inst_valid}, 32'h1);
        end
        stalled = '0;
        wait_drain(60);

        // 3: branch to 0x102 with two words outstanding
        do_reset(6);
        rsp_hold = 1'b1;
        addr_exp = '{32'h0, 32'h4, 32'h100, 32'h104, 32'h108, 32'h10C};
        exp_q    = '{33'h100, 33'h104, 33'h108, 33'h10C};
        wait_req();
        tick();
        tick();
        check("t3_req_maxout", {31'b0, bus.ibus_req_o}, 32'h0);
        br_flag = 1'b1;
        br_addr = 32'h0000_0102;
        tick();
        br_flag  = 1'b0;
        rsp_hold = 1'b0;
        check("t3_addr", bus.ibus_addr_o, 32'h100);
        check("t3_pc_empty", pc_o, 32'h100);
        check("t3_valid", {31'b0, inst_valid}, 32'h0);
        wait_drain(60);

        // 4: redirect coincides with rvalid and gnt
        do_reset(5);
        addr_exp = '{32'h0, 32'h4, 32'h200, 32'h204, 32'h208};
        exp_q    = '{33'h200, 33'h204, 33'h208};
        wait_req();
        tick();
        check("t4_req", {31'b0, bus.ibus_req_o}, 32'h1);
        check("t4_addr_pre", bus.ibus_addr_o, 32'h4);
        br_flag = 1'b1;
        br_addr = 32'h0000_0200;
        tick();
        br_flag = 1'b0;
        check("t4_valid", {31'b0, inst_valid}, 32'h0);
        check("t4_addr", bus.ibus_addr_o, 32'h200);
        check("t4_pc_empty", pc_o, 32'h200);
        wait_drain(60);

        // 5: gnt withheld across a flush redirect
        do_reset(4);
        gnt_en   = 1'b0;
        addr_exp = '{32'h0, 32'h100, 32'h104, 32'h108};
        exp_q    = '{33'h100, 33'h104, 33'h108};
        wait_req();
        check("t5_addr0", bus.ibus_addr_o, 32'h0);
        flush   = 6'b000001;
        br_addr = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            flush = '0;
            check("t5_req_held", {31'b0, bus.ibus_req_o}, 32'h1);
            check("t5_addr_held", bus.ibus_addr_o, 32'h0);
        end
        check("t5_pc_empty", pc_o, 32'h100);
        gnt_en = 1'b1;
        wait_drain(60);

`ifdef IBUS_ERR_EN
        // 6: bus error on word 0x8 halts fetch until redirect
        do_reset(6);
        err_en   = 1'b1;
        err_addr = 32'h8;
        addr_exp = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h200, 32'h204};
        exp_q    = '{33'h0, 33'h4, {1'b1, 32'h8}, 33'hC, 33'h200, 33'h204};
        wait_req();
        repeat (10) tick();
        check("t6_req_blocked", {31'b0, bus.ibus_req_o}, 32'h0);
        br_flag = 1'b1;
        br_addr = 32'h0000_0200;
        tick();
        br_flag = 1'b0;
        err_en  = 1'b0;
        check("t6_req_resume", {31'b0, bus.ibus_req_o}, 32'h1);
        check("t6_addr_resume", bus.ibus_addr_o, 32'h200);
        wait_drain(60);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
